spi_reg_responder: RTL and testbench

- SPI mode-0 responder: the target end of the SPI link that the SoC's SPI master drives toward the USB host chip.
- Implements a 32 x 8 register file. The command format follows the USB host controller's: command byte, then data bytes.
- Used as an in-fabric stand-in for the host chip, and as a register window that the SoC can poke over SPI.
- The fabric side gets a local read/write port and a write-strobe output (e.g. to feed keycode or LED logic).

---
 rtl/spi_reg_responder.sv | 192 +++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// SPI mode-0 target with a 32 x 8 register file.
// Command byte {addr[4:0], x, dir, x} followed by data bytes. The address
// auto-increments and wraps after every data byte. A local fabric port gives
// direct read/write access to the register file, and a write strobe reports
// every byte written over SPI.
module spi_reg_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SCLK,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_oe,
  input  logic [7:0] status_in,
  input  logic [4:0] lcl_addr,
  input  logic       lcl_we,
  input  logic [7:0] lcl_wdata,
  output logic [7:0] lcl_rdata,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [NS-1:0] sclk_sync, ss_sync, mosi_sync;
  logic          sclk_q, ss_q;
  logic          sclk_s, ss_s, mosi_s;
  logic          rise, fall, ss_fall;

  state_t      state, state_nx;
  logic [2:0]  bitcnt, bitcnt_nx;
  logic [7:0]  rx_shift, rx_nx, rx_byte;
  logic [6:0]  tx_shift, tx_nx;   // bits still to be shifted out below MISO
  logic [4:0]  addr, addr_nx, addr_inc;
  logic        dir, dir_nx;
  logic        miso_nx, oe_nx, busy_nx;
  logic        spi_we;
  logic [7:0]  rd_cmd, rd_next;

  logic [7:0]  regs [32];

  // Synchronizers and edge-detect history. They clear to 0 so that an SS_n
  // held low across reset is never mistaken for a new select: a transaction
  // only starts after SS_n is seen high and then low again.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[NS-2:0], SCLK};
      ss_sync   <= {ss_sync[NS-2:0], SS_n};
      mosi_sync <= {mosi_sync[NS-2:0], MOSI};
      sclk_q    <= sclk_sync[NS-1];
      ss_q      <= ss_sync[NS-1];
    end
  end

  assign sclk_s   = sclk_sync[NS-1];
  assign ss_s     = ss_sync[NS-1];
  assign mosi_s   = mosi_sync[NS-1];
  assign rise     = sclk_s & ~sclk_q;
  assign fall     = ~sclk_s & sclk_q;
  assign ss_fall  = ~ss_s & ss_q;

  assign rx_byte  = {rx_shift[6:0], mosi_s};
  assign addr_inc = addr + 5'd1;
  assign rd_cmd   = regs[rx_byte[7:3]];
  assign rd_next  = regs[addr_inc];
  assign lcl_rdata = regs[lcl_addr];

  // Next-state and datapath decode. The fall that follows a byte's 8th rise
  // (bitcnt back at 0) must not shift: the next byte's MSB was just placed on
  // MISO by that rise and has to survive until the following rise.
  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    rx_nx     = rx_shift;
    tx_nx     = tx_shift;
    addr_nx   = addr;
    dir_nx    = dir;
    miso_nx   = MISO;
    oe_nx     = MISO_oe;
    busy_nx   = busy;
    spi_we    = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx  = CMD;
          tx_nx     = status_in[6:0];
          miso_nx   = status_in[7];
          bitcnt_nx = 3'd0;
          rx_nx     = 8'h00;
          oe_nx     = 1'b1;
          busy_nx   = 1'b1;
        end
      end
      default: begin
        if (ss_s) begin
          // deselect wins over any same-cycle edge; partial byte dropped
          state_nx  = IDLE;
          miso_nx   = 1'b0;
          oe_nx     = 1'b0;
          busy_nx   = 1'b0;
          bitcnt_nx = 3'd0;
        end else if (rise) begin
          rx_nx     = rx_byte;
          bitcnt_nx = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            if (state == CMD) begin
              state_nx = DATA;
              addr_nx  = rx_byte[7:3];
              dir_nx   = rx_byte[1];
              if (!rx_byte[1]) begin
                tx_nx   = rd_cmd[6:0];
                miso_nx = rd_cmd[7];
              end
            end else begin
              addr_nx = addr_inc;
              if (dir) begin
                spi_we = 1'b1;
              end else begin
                tx_nx   = rd_next[6:0];
                miso_nx = rd_next[7];
              end
            end
          end
        end else if (fall && bitcnt != 3'd0) begin
          miso_nx = tx_shift[6];
          tx_nx   = {tx_shift[5:0], 1'b0};
        end
      end
    endcase
  end

  // State, shift registers and SPI-facing outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      bitcnt    <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 7'h00;
      addr      <= 5'd0;
      dir       <= 1'b0;
      MISO      <= 1'b0;
      MISO_oe   <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 8'h00;
    end else begin
      state     <= state_nx;
      bitcnt    <= bitcnt_nx;
      rx_shift  <= rx_nx;
      tx_shift  <= tx_nx;
      addr      <= addr_nx;
      dir       <= dir_nx;
      MISO      <= miso_nx;
      MISO_oe   <= oe_nx;
      busy      <= busy_nx;
      wr_strobe <= spi_we;
      if (spi_we) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
    end
  end

  // Register file: SPI write has priority over a local write to the same entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (spi_we && addr == 5'(i))
          regs[i] <= rx_byte;
        else if (lcl_we && lcl_addr == 5'(i))
          regs[i] <= lcl_wdata;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: directed table, corner-case sequences and
// randomized transactions against an array-based register model.
module tb_spi_reg_responder;

  localparam int NS   = 2;
  localparam int HALF = 4;   // SCLK half period in Clk cycles (SCLK = Clk/8)

  logic       clk = 1'b0;
  logic       Reset, SCLK, SS_n, MOSI;
  logic       MISO, MISO_oe, wr_strobe, busy;
  logic [7:0] status_in, lcl_wdata, lcl_rdata, wr_data;
  logic [4:0] lcl_addr, wr_addr;
  logic       lcl_we;

  spi_reg_responder #(.SYNC_STAGES(NS), .RESET_VAL(8'h00)) dut (
    .Clk(clk), .Reset(Reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .status_in(status_in),
    .lcl_addr(lcl_addr), .lcl_we(lcl_we), .lcl_wdata(lcl_wdata),
    .lcl_rdata(lcl_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  model [32];
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];

  // capture every SPI write strobe as {addr, data}
  always @(negedge clk) if (wr_strobe === 1'b1) got_q.push_back({wr_addr, wr_data});

  typedef struct {
    logic [7:0] status;
    logic [7:0] cmd;
    int         n;
    logic [7:0] d0, d1;
    logic [2:0] chk;       // which MISO bytes are compared
    logic [7:0] e0, e1, e2;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input logic [4:0] a);
    @(negedge clk);
    lcl_addr = a;
    #1;
    chk($sformatf("reg[%0d]", a), 32'(lcl_rdata), 32'(model[a]));
  endtask

  task automatic check_strobes(input string name);
    int m;
    chk({name, "_strobe_count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({name, "_strobe"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic lcl_write(input logic [4:0] a, input logic [7:0] v);
    @(negedge clk);
    lcl_addr = a; lcl_wdata = v; lcl_we = 1'b1;
    @(negedge clk);
    lcl_we = 1'b0;
    model[a] = v;
  endtask

  // master side: shift nb bits MSB first, sampling MISO just before each rise
  task automatic spi_byte(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nb; i--) begin
      MOSI = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = MISO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (NS + 3) @(negedge clk);
    chk("idle_outputs", {busy, MISO_oe, MISO}, 3'b000);
  endtask

  task automatic spi_xfer(input logic [7:0] st, input logic [7:0] cmd, input int n,
                          input logic [3:0][7:0] d, output logic [4:0][7:0] r);
    logic [7:0] b;
    r = '0;
    status_in = st;
    SS_n = 1'b0;
    spi_byte(cmd, 8, b);
    r[0] = b;
    chk("busy_oe_active", {busy, MISO_oe}, 2'b11);
    for (int k = 0; k < n; k++) begin
      spi_byte(d[k], 8, b);
      r[k+1] = b;
    end
    spi_end();
  endtask

  // reference: status first, then consecutive registers (read) or register
  // updates plus strobes (write), address wrapping modulo 32
  task automatic model_xfer(input logic [7:0] st, input logic [7:0] cmd, input int n,
                            input logic [3:0][7:0] d, output logic [4:0][7:0] e);
    int a;
    e = '0;
    e[0] = st;
    a = int'(cmd[7:3]);
    for (int k = 0; k < n; k++) begin
      if (cmd[1]) begin
        model[a] = d[k];
        exp_q.push_back({5'(a), d[k]});
      end else begin
        e[k+1] = model[a];
      end
      a = (a + 1) % 32;
    end
  endtask

  initial begin
    logic [3:0][7:0] d;
    logic [4:0][7:0] r, e;
    logic [7:0] b, cmd, st;
    int n;

    Reset = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    status_in = 8'h00; lcl_addr = 5'd0; lcl_we = 1'b0; lcl_wdata = 8'h00;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    repeat (NS + 2) @(negedge clk);

    // reset state
    chk("reset_outputs", {MISO, MISO_oe, busy, wr_strobe}, 4'b0000);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    chk_reg(5'd10);

    // directed table
    tbl[0] = '{8'h00, 8'h52, 2, 8'hA5, 8'h3C, 3'b001, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{8'h81, 8'h50, 2, 8'h00, 8'h00, 3'b111, 8'h81, 8'hA5, 8'h3C};
    tbl[2] = '{8'h7E, 8'hFA, 2, 8'h96, 8'h69, 3'b001, 8'h7E, 8'h00, 8'h00};
    tbl[3] = '{8'h42, 8'hF8, 2, 8'hFF, 8'hFF, 3'b111, 8'h42, 8'h96, 8'h69};
    tbl[4] = '{8'h18, 8'h55, 2, 8'h00, 8'h00, 3'b111, 8'h18, 8'hA5, 8'h3C};
    tbl[5] = '{8'hE7, 8'h56, 2, 8'h11, 8'h22, 3'b001, 8'hE7, 8'h00, 8'h00};
    tbl[6] = '{8'h00, 8'h50, 2, 8'h00, 8'h00, 3'b111, 8'h00, 8'h11, 8'h22};
    for (int i = 0; i < 7; i++) begin
      d = '0;
      d[0] = tbl[i].d0;
      d[1] = tbl[i].d1;
      model_xfer(tbl[i].status, tbl[i].cmd, tbl[i].n, d, e);
      spi_xfer(tbl[i].status, tbl[i].cmd, tbl[i].n, d, r);
      if (tbl[i].chk[0]) chk($sformatf("tbl%0d_miso0", i), 32'(r[0]), 32'(tbl[i].e0));
      if (tbl[i].chk[1]) chk($sformatf("tbl%0d_miso1", i), 32'(r[1]), 32'(tbl[i].e1));
      if (tbl[i].chk[2]) chk($sformatf("tbl%0d_miso2", i), 32'(r[2]), 32'(tbl[i].e2));
      check_strobes($sformatf("tbl%0d", i));
      if (i == 0) begin
        @(negedge clk);
        lcl_addr = 5'd11;
        #1;
        chk("burst_lcl_rdata11", 32'(lcl_rdata), 32'h3C);
      end
    end

    // read with status, registers preloaded through the local port, 31->0 wrap
    lcl_write(5'd31, 8'h5A);
    lcl_write(5'd0, 8'hC3);
    d = '0;
    spi_xfer(8'h81, 8'hF8, 2, d, r);
    chk("rdwrap_status", 32'(r[0]), 32'h81);
    chk("rdwrap_reg31", 32'(r[1]), 32'h5A);
    chk("rdwrap_reg0", 32'(r[2]), 32'hC3);
    check_strobes("rdwrap");

    // abort mid-byte: write cmd to addr 4, only 5 data bits
    lcl_write(5'd4, 8'h6D);
    status_in = 8'h00;
    SS_n = 1'b0;
    spi_byte(8'h22, 8, b);
    spi_byte(8'hFF, 5, b);
    spi_end();
    check_strobes("abort");
    chk_reg(5'd4);
    d = '0;
    model_xfer(8'h3C, 8'h20, 1, d, e);
    spi_xfer(8'h3C, 8'h20, 1, d, r);
    chk("after_abort_status", 32'(r[0]), 32'(e[0]));
    chk("after_abort_reg4", 32'(r[1]), 32'(e[1]));

    // collision: local write 11 to addr 7 in the same cycle as the SPI write of 22
    status_in = 8'h00;
    SS_n = 1'b0;
    spi_byte(8'h3A, 8, b);
    spi_byte(8'h22, 7, b);
    MOSI = 1'b0;
    repeat (HALF) @(negedge clk);
    SCLK = 1'b1;
    repeat (NS) @(posedge clk);
    @(negedge clk);
    lcl_addr = 5'd7; lcl_wdata = 8'h11; lcl_we = 1'b1;
    @(negedge clk);
    lcl_we = 1'b0;
    repeat (HALF - 2) @(negedge clk);
    SCLK = 1'b0;
    spi_end();
    model[7] = 8'h22;
    exp_q.push_back({5'd7, 8'h22});
    check_strobes("collision");
    chk_reg(5'd7);

    // reset in the middle of a write burst, SS_n left low afterwards
    status_in = 8'h00;
    SS_n = 1'b0;
    spi_byte(8'h62, 8, b);
    spi_byte(8'hAB, 8, b);
    model[12] = 8'hAB;
    exp_q.push_back({5'd12, 8'hAB});
    spi_byte(8'hFF, 3, b);
    Reset = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {MISO, MISO_oe, busy, wr_strobe}, 4'b0000);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    lcl_addr = 5'd12;
    #1;
    chk("midrst_reg12", 32'(lcl_rdata), 32'h00);
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    check_strobes("midrst_before");
    spi_byte(8'h52, 8, b);
    spi_byte(8'hFF, 8, b);
    chk("midrst_ignored", {busy, MISO_oe, MISO}, 3'b000);
    check_strobes("midrst_ignored");
    chk_reg(5'd10);
    SS_n = 1'b1;
    repeat (NS + 3) @(negedge clk);
    d = '0;
    d[0] = 8'h77;
    model_xfer(8'h99, 8'h52, 1, d, e);
    spi_xfer(8'h99, 8'h52, 1, d, r);
    chk("midrst_new_status", 32'(r[0]), 32'h99);
    check_strobes("midrst_new");
    chk_reg(5'd10);

    // SCLK/MOSI noise while deselected
    SS_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      MOSI = 1'($urandom);
      SCLK = ~SCLK;
      repeat (HALF) @(negedge clk);
      if (i % 10 == 9) chk("noise_idle", {busy, MISO_oe, MISO}, 3'b000);
    end
    SCLK = 1'b0;
    repeat (HALF) @(negedge clk);
    check_strobes("noise");

    // randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) lcl_write(5'($urandom), 8'($urandom));
      st  = 8'($urandom);
      cmd = 8'($urandom);
      n   = $urandom_range(0, 3);
      d   = 32'($urandom);
      model_xfer(st, cmd, n, d, e);
      spi_xfer(st, cmd, n, d, r);
      chk("rnd_status", 32'(r[0]), 32'(e[0]));
      if (!cmd[1])
        for (int k = 0; k < n; k++) chk("rnd_read", 32'(r[k+1]), 32'(e[k+1]));
      check_strobes("rnd");
    end
    for (int i = 0; i < 32; i++) chk_reg(5'(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
